// File: rtl/serial_sub.sv
// ---------------------------------------------------------------------------
// serial_sub
//   Bit-serial subtractor: D = A - B (mod 2^WIDTH), one bit per clock, LSB
//   first, through a single full-subtractor cell with a registered borrow.
//   A start/done handshake allows one operation in flight at a time.
//
//   Optional feature: define SERIAL_SUB_OVF_EN to register a signed
//   overflow flag on OVF. When the macro is undefined OVF is tied to 0 and
//   no extra flops exist.
//
// Ports
//   clk   : rising-edge clock
//   rst   : asynchronous reset, active-high
//   start : request, sampled only while idle
//   A, B  : minuend / subtrahend, captured on an accepted start
//   busy  : high from the cycle after an accepted start until done
//   done  : single-cycle pulse when D/Bout/OVF are valid
//   D     : registered difference, held until the next result or reset
//   Bout  : final borrow (1 when A < B unsigned)
//   OVF   : signed overflow flag (0 unless SERIAL_SUB_OVF_EN is defined)
// ---------------------------------------------------------------------------
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             OVF
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  sa_q, sa_d;
    logic [WIDTH-1:0]  sb_q, sb_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic              bw_q, bw_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  d_q, d_d;
    logic              bout_q, bout_d;

    // Full-subtractor cell on the current LSBs.
    logic bit_a, bit_b, diff_bit, borrow_bit;
    assign bit_a      = sa_q[0];
    assign bit_b      = sb_q[0];
    assign diff_bit   = bit_a ^ bit_b ^ bw_q;
    assign borrow_bit = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & bw_q);

    // An accepted start is one seen while idle; a start on the edge that
    // leaves DONE is sampled in DONE and therefore dropped.
    logic accept;
    assign accept = (state_q == S_IDLE) && start;

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        bw_d    = bw_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        d_d     = d_q;
        bout_d  = bout_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_d    = A;
                    sb_d    = B;
                    sr_d    = '0;
                    bw_d    = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Difference bits enter at the MSB, so after WIDTH shifts
                // the LSB-first stream sits in natural bit order.
                sr_d  = {diff_bit, sr_q[WIDTH-1:1]};
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                bw_d  = borrow_bit;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                d_d     = sr_q;
                bout_d  = bw_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            bw_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            bw_q    <= bw_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign D    = d_q;
    assign Bout = bout_q;

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are captured at start because the shift registers
    // have lost them by the time the result is written.
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;

    always_comb begin
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
        if (accept) begin
            a_msb_d = A[WIDTH-1];
            b_msb_d = B[WIDTH-1];
        end
        if (state_q == S_DONE) begin
            // Signs differ and the result sign disagrees with the minuend.
            ovf_d = (a_msb_q != b_msb_q) && (sr_q[WIDTH-1] != a_msb_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign OVF = ovf_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign OVF = 1'b0;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// ---------------------------------------------------------------------------
// tb_serial_sub
//   Self-checking bench for serial_sub (WIDTH=8). A behavioural model tracks
//   the expected handshake timing and results with plain arithmetic; a single
//   compare process checks every output on each falling edge, and the
//   directed operations are additionally pinned to hand-computed results.
// ---------------------------------------------------------------------------
module tb_serial_sub;

    localparam int W      = 8;
    localparam int N_LIT  = 7;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] d_out;
    logic         bout;
    logic         ovf;

    serial_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a_in),
        .B     (b_in),
        .busy  (busy),
        .done  (done),
        .D     (d_out),
        .Bout  (bout),
        .OVF   (ovf)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic         m_inflight = 1'b0;
    int           m_age      = 0;
    logic [W-1:0] m_a        = '0;
    logic [W-1:0] m_b        = '0;
    logic         m_done     = 1'b0;
    logic [W-1:0] m_d        = '0;
    logic         m_bout     = 1'b0;
    logic         m_ovf      = 1'b0;

    function automatic logic signed_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SERIAL_SUB_OVF_EN
        int diff;
        diff = int'($signed(x)) - int'($signed(y));
        return (diff > (2 ** (W - 1)) - 1) || (diff < -(2 ** (W - 1)));
`else
        return (x != x);
`endif
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_inflight = 1'b0;
                m_age      = 0;
                m_done     = 1'b0;
                m_d        = '0;
                m_bout     = 1'b0;
                m_ovf      = 1'b0;
            end else begin
                m_done = 1'b0;
                if (m_inflight) begin
                    m_age = m_age + 1;
                    // Result appears WIDTH+1 edges after the accepting edge.
                    if (m_age == W + 1) begin
                        m_done     = 1'b1;
                        m_d        = W'(int'(m_a) - int'(m_b));
                        m_bout     = (m_a < m_b);
                        m_ovf      = signed_ovf(m_a, m_b);
                        m_inflight = 1'b0;
                    end
                end else if (start) begin
                    m_inflight = 1'b1;
                    m_age      = 0;
                    m_a        = a_in;
                    m_b        = b_in;
                end
            end
        end
    end

    // ---------------- literal expectations for directed ops ----------------
    logic [W-1:0] lit_d    [N_LIT];
    logic         lit_bout [N_LIT];
    logic         lit_ovf  [N_LIT];

    // ---------------- compare process ----------------
    int   checks = 0;
    int   errors = 0;
    logic chk_en = 1'b0;
    logic final_req = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        int   dcnt;
        int   mcnt;
        logic final_taken;
        logic exp_busy;
        dcnt        = 0;
        mcnt        = 0;
        final_taken = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp_busy = m_inflight && (m_age < W);
                chk("busy", 32'(busy), 32'(exp_busy));
                chk("done", 32'(done), 32'(m_done));
                chk("D",    32'(d_out), 32'(m_d));
                chk("Bout", 32'(bout), 32'(m_bout));
                chk("OVF",  32'(ovf), 32'(m_ovf));
                if (done === 1'b1) begin
                    if (dcnt < N_LIT) begin
                        chk($sformatf("lit_D[%0d]", dcnt),    32'(d_out), 32'(lit_d[dcnt]));
                        chk($sformatf("lit_Bout[%0d]", dcnt), 32'(bout),  32'(lit_bout[dcnt]));
                        chk($sformatf("lit_OVF[%0d]", dcnt),  32'(ovf),   32'(lit_ovf[dcnt]));
                    end
                    dcnt = dcnt + 1;
                end
                if (m_done) mcnt = mcnt + 1;
                if (dcnt == N_LIT && mcnt == N_LIT && !final_taken && final_req) begin
                    final_taken = 1'b1;
                end
                if (final_req && !final_taken) begin
                    chk("done_count", 32'(dcnt), 32'(mcnt));
                    chk("done_count_min", 32'(dcnt >= N_LIT), 32'd1);
                    final_taken = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse(input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        lit_d[0] = 8'h02; lit_bout[0] = 1'b0; lit_ovf[0] = 1'b0;
        lit_d[1] = 8'hFE; lit_bout[1] = 1'b1; lit_ovf[1] = 1'b0;
        lit_d[2] = 8'h7F; lit_bout[2] = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        lit_ovf[2] = 1'b1;
`else
        lit_ovf[2] = 1'b0;
`endif
        lit_d[3] = 8'h00; lit_bout[3] = 1'b0; lit_ovf[3] = 1'b0;
        lit_d[4] = 8'h00; lit_bout[4] = 1'b0; lit_ovf[4] = 1'b0;
        lit_d[5] = 8'h30; lit_bout[5] = 1'b0; lit_ovf[5] = 1'b0;
        lit_d[6] = 8'h05; lit_bout[6] = 1'b0; lit_ovf[6] = 1'b0;

        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        gap(2);
        rst = 1'b0;
        gap(2);

        pulse(8'h05, 8'h03); gap(W + 4);
        pulse(8'h03, 8'h05); gap(W + 4);
        pulse(8'h80, 8'h01); gap(W + 4);

        // Back-to-back at the minimum issue interval.
        pulse(8'h00, 8'h00); gap(W + 1);
        pulse(8'hFF, 8'hFF); gap(W + 4);

        // Second request during RUN must be ignored.
        pulse(8'h40, 8'h10); gap(2);
        pulse(8'h11, 8'h22); gap(W + 4);

        // Reset in the middle of an operation aborts it.
        pulse(8'hAA, 8'h55); gap(3);
        rst = 1'b1;
        gap(2);
        rst = 1'b0;
        gap(1);
        pulse(8'h09, 8'h04); gap(W + 4);

        // Randomised traffic with start noise and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(3) == 0);
            a_in  = W'($urandom);
            b_in  = W'($urandom);
            rst   = ($urandom_range(599) == 0);
            gap(1);
        end
        start = 1'b0;
        rst   = 1'b0;
        gap(W + 4);

        final_req = 1'b1;
        gap(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
